// File: rtl/logic_ops_pkg.sv
// rtl/logic_ops_pkg.sv - shared op codes and FSM state encoding for the slice-serial logic unit
package logic_ops_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOT_A = 3'd3;
    localparam logic [2:0] OP_NAND  = 3'd4;
    localparam logic [2:0] OP_NOR   = 3'd5;
    localparam logic [2:0] OP_XNOR  = 3'd6;
    localparam logic [2:0] OP_PASS  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_slice.sv
// rtl/logic_slice.sv - combinational per-slice bitwise operation
// Ports: a, b - operand slices; op - operation select; y - slice result.
module logic_slice
    import logic_ops_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOT_A: y = ~a;
            OP_NAND:  y = ~(a & b);
            OP_NOR:   y = ~(a | b);
            OP_XNOR:  y = ~(a ^ b);
            OP_PASS:  y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - slice-serial bitwise logic unit, one SLICE-bit slice per clock
// Ports: clk, rst (async active-high); start, op, a, b - request and operands;
//        busy - slices in progress; done - one-cycle result-valid pulse;
//        f - registered result; zero - f is zero, qualified by done.
module bitwise_logic_unit
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_cap;
    logic [WIDTH-1:0]  b_cap;
    logic [2:0]        op_cap;
    logic              zero_q;

    logic [SLICE-1:0]  a_sl;
    logic [SLICE-1:0]  b_sl;
    logic [SLICE-1:0]  y_sl;
    logic [WIDTH-1:0]  f_next;

    // Only captured operands feed the datapath, so input changes while busy
    // cannot reach the result.
    assign a_sl = a_cap[cnt*SLICE +: SLICE];
    assign b_sl = b_cap[cnt*SLICE +: SLICE];

    logic_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .op (op_cap),
        .y  (y_sl)
    );

    // Result with the current slice merged in; also used to compute the zero
    // flag on the final slice so zero is registered alongside done.
    always_comb begin
        f_next = f;
        f_next[cnt*SLICE +: SLICE] = y_sl;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            a_cap  <= '0;
            b_cap  <= '0;
            op_cap <= '0;
            f      <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    zero_q <= 1'b0;
                    if (start) begin
                        a_cap  <= a;
                        b_cap  <= b;
                        op_cap <= op;
                        f      <= '0;
                        cnt    <= '0;
                        state  <= ST_BUSY;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    f   <= f_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_SLICE) begin
                        state  <= ST_DONE;
                        zero_q <= (f_next == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);
    assign zero = zero_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - self-checking bench for bitwise_logic_unit
module tb_bitwise_logic_unit;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  f;
    logic              zero;

    logic              d_start;
    logic [2:0]        d_op;
    logic [7:0]        d_a;
    logic [7:0]        d_b;
    logic              d_busy;
    logic              d_done;
    logic [7:0]        d_f;
    logic              d_zero;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .f(f), .zero(zero)
    );

    bitwise_logic_unit #(.WIDTH(8), .SLICE(8)) dut_deg (
        .clk(clk), .rst(rst), .start(d_start), .op(d_op), .a(d_a), .b(d_b),
        .busy(d_busy), .done(d_done), .f(d_f), .zero(d_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_op(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~x;
            3'd4: return ~(x & y);
            3'd5: return ~(x | y);
            3'd6: return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] low_mask(input int nbits);
        longint m;
        m = (64'd1 << nbits) - 64'd1;
        return m[WIDTH-1:0];
    endfunction

    // Reference model: an accepted request has a known final answer; the
    // visible result is that answer revealed one slice per cycle from the LSB.
    int               m_rem;
    int               m_k;
    bit               m_done;
    logic [WIDTH-1:0] m_final;
    logic [WIDTH-1:0] m_f;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem = 0; m_k = 0; m_done = 0; m_final = '0; m_f = '0;
        end else if (m_rem > 0) begin
            m_k++;
            m_rem--;
            m_f    = m_final & low_mask(m_k * SLICE);
            m_done = (m_rem == 0);
        end else begin
            m_done = 0;
            if (start) begin
                m_final = model_op(op, a, b);
                m_f     = '0;
                m_k     = 0;
                m_rem   = NSLICE;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_busy", busy, m_rem > 0);
            chk("model_done", done, m_done);
            chk("model_f",    f,    m_f);
            chk("model_zero", zero, m_done && (m_f == '0));
        end
    end

    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic [2:0] top,
                         output logic [15:0] rf, output logic rz, output int lat);
        a = ta; b = tb; op = top; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            lat++;
            if (lat > 20) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        rf = f;
        rz = zero;
    endtask

    logic [15:0] sweep_exp [8] = '{16'h05C0, 16'hAFF3, 16'hAA33, 16'h5A3C,
                                   16'hFA3F, 16'h500C, 16'h55CC, 16'hA5C3};

    initial begin
        logic [15:0] rf;
        logic        rz;
        int          lat;
        int          ndone;
        time         t_done [$];

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        d_start = 1'b0; d_op = '0; d_a = '0; d_b = '0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_f",    f,    0);
        chk("reset_zero", zero, 0);
        #11 rst = 1'b0;
        cmp_en = 1'b1;

        // Basic AND, issued on the first edge after reset
        do_op(16'hF0F0, 16'hFF00, 3'd0, rf, rz, lat);
        chk("basic_latency", lat, 4);
        chk("basic_f",       rf,  16'hF000);
        chk("basic_zero",    rz,  0);

        for (int i = 0; i < 8; i++) begin
            do_op(16'hA5C3, 16'h0FF0, 3'(i), rf, rz, lat);
            chk($sformatf("sweep_op%0d_f", i), rf, sweep_exp[i]);
            chk($sformatf("sweep_op%0d_lat", i), lat, 4);
        end

        do_op(16'h1234, 16'h1234, 3'd2, rf, rz, lat);
        chk("zero_f",    rf, 16'h0000);
        chk("zero_flag", rz, 1);
        @(negedge clk);
        chk("zero_after_done", zero, 0);
        chk("f_hold_idle", f, 16'h0000);

        // Operand change and start while busy are ignored
        a = 16'hFFFF; b = 16'hFFFF; op = 3'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 a = 16'h0000; op = 3'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0; rf = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin ndone++; rf = f; end
        end
        chk("midop_done_count", ndone, 1);
        chk("midop_f", rf, 16'hFFFF);

        // Back-to-back with start held high
        a = 16'h1234; b = 16'h00FF; op = 3'd0; start = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40 && ndone < 3; i++) begin
            @(negedge clk);
            if (done) begin
                t_done.push_back($time);
                ndone++;
                if (ndone == 1) begin
                    chk("b2b_f1", f, 16'h0034);
                    a = 16'h1200; b = 16'h0034; op = 3'd1;
                end else if (ndone == 2) begin
                    chk("b2b_f2", f, 16'h1234);
                    a = 16'hFFFF; b = 16'h0F0F; op = 3'd2;
                end else begin
                    chk("b2b_f3", f, 16'hF0F0);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", ndone, 3);
        if (t_done.size() == 3) begin
            chk("b2b_period1", 32'(t_done[1] - t_done[0]), 50);
            chk("b2b_period2", 32'(t_done[2] - t_done[1]), 50);
        end
        repeat (2) @(negedge clk);

        // Reset abort mid-operation
        a = 16'hFFFF; b = 16'h0000; op = 3'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("abort_pre_f", f, 16'h00FF);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_f",    f,    0);
        chk("abort_zero", zero, 0);
        @(negedge clk); #1 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        do_op(16'h00FF, 16'h0F0F, 3'd6, rf, rz, lat);
        chk("post_abort_f",   rf,  16'hF00F);
        chk("post_abort_lat", lat, 4);

        // Degenerate single-slice instance
        @(negedge clk);
        d_a = 8'hFF; d_b = 8'h0F; d_op = 3'd4; d_start = 1'b1;
        @(posedge clk); #1 d_start = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (d_done) break;
            chk("deg_busy", d_busy, 1);
            lat++;
            if (lat > 10) begin
                chk("deg_timeout", 0, 1);
                break;
            end
        end
        chk("deg_latency", lat, 1);
        chk("deg_f",       d_f, 8'hF0);
        chk("deg_zero",    d_zero, 0);
        @(negedge clk);
        chk("deg_done_pulse", d_done, 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
